// File: rtl/age_tag_allocator_pkg.sv
// Shared definitions for the age-tag allocator.
//   ENT_NUM            : window size (fixed at 8 slots)
//   ENTLEN_DEF         : default entry index width
//   VALLEN_DEF         : default age value width
//   age_invalid()      : age presented for an empty slot (all-ones)
//   age_limit()        : counter value that triggers compaction
//   state_e            : allocator state (RUN, COMPACT)
package age_tag_allocator_pkg;

    localparam int unsigned ENT_NUM    = 8;
    localparam int unsigned ENTLEN_DEF = 3;
    localparam int unsigned VALLEN_DEF = 8;

    function automatic logic [63:0] age_invalid(input int unsigned vallen);
        return (64'd1 << vallen) - 64'd1;
    endfunction

    function automatic logic [63:0] age_limit(input int unsigned vallen);
        return (64'd1 << vallen) - 64'd2;
    endfunction

    typedef enum logic {
        ST_RUN,
        ST_COMPACT
    } state_e;

endpackage

// File: rtl/age_tag_allocator_compactor.sv
// age_rank_compactor: combinational rank computation for age compaction.
// Each valid slot's rank is the number of other valid slots holding a
// smaller age; invalid slots never contribute and report rank 0.
//   valid_i      : per-slot valid
//   age_i        : per-slot age, slot i at [i*VALLEN +: VALLEN]
//   rank_o       : per-slot rank, slot i at [i*ENTLEN +: ENTLEN]
//   live_count_o : number of valid slots
module age_rank_compactor
    import age_tag_allocator_pkg::*;
#(
    parameter int unsigned ENTLEN = ENTLEN_DEF,
    parameter int unsigned VALLEN = VALLEN_DEF
) (
    input  logic [ENT_NUM-1:0]        valid_i,
    input  logic [ENT_NUM*VALLEN-1:0] age_i,
    output logic [ENT_NUM*ENTLEN-1:0] rank_o,
    output logic [ENTLEN:0]           live_count_o
);

    // older[i][j]: slot j is valid and strictly older than valid slot i
    logic [ENT_NUM-1:0] older [ENT_NUM];
    logic [ENTLEN:0]    rank_acc;
    logic [ENTLEN:0]    live_acc;

    always_comb begin
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            older[i] = '0;
            for (int unsigned j = 0; j < ENT_NUM; j++) begin
                if (i != j) begin
                    older[i][j] = valid_i[i] && valid_i[j] &&
                                  (age_i[j*VALLEN +: VALLEN] < age_i[i*VALLEN +: VALLEN]);
                end
            end
        end
    end

    // At most 7 other slots can be older, so the rank fits in ENTLEN bits.
    always_comb begin
        rank_o   = '0;
        rank_acc = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            rank_acc = '0;
            for (int unsigned j = 0; j < ENT_NUM; j++) begin
                rank_acc = rank_acc + (ENTLEN+1)'(older[i][j]);
            end
            rank_o[i*ENTLEN +: ENTLEN] = rank_acc[ENTLEN-1:0];
        end
    end

    always_comb begin
        live_acc = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            live_acc = live_acc + (ENTLEN+1)'(valid_i[i]);
        end
        live_count_o = live_acc;
    end

endmodule

// File: rtl/age_tag_allocator.sv
// Age-tag allocator for an 8-entry scheduling window. Grants the lowest
// free slot with a strictly increasing age, releases slots on request, and
// presents every slot's (index, age) pair for the oldest-entry selector.
// When the age counter reaches its ceiling, one COMPACT cycle rewrites all
// live ages to their ranks so the ordering never wraps.
// Optional feature macro: AGE_ALLOC_BYPASS_EN (full-window free->alloc reuse).
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   alloc_req_i       : allocation request
//   alloc_ready_o     : allocation accepted this cycle
//   alloc_entry_o     : granted slot
//   alloc_age_o       : granted age (current counter)
//   free_valid_i      : release request
//   free_entry_i      : slot to release
//   entry_vector_o    : constant slot indices, slot i at [i*ENTLEN +: ENTLEN]
//   value_vector_o    : slot ages, all-ones for invalid slots
//   valid_vector_o    : per-slot valid
//   count_o           : number of valid slots
//   compact_busy_o    : high during the COMPACT cycle
module age_tag_allocator
    import age_tag_allocator_pkg::*;
#(
    parameter int unsigned ENTLEN = ENTLEN_DEF,
    parameter int unsigned VALLEN = VALLEN_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alloc_req_i,
    output logic                      alloc_ready_o,
    output logic [ENTLEN-1:0]         alloc_entry_o,
    output logic [VALLEN-1:0]         alloc_age_o,
    input  logic                      free_valid_i,
    input  logic [ENTLEN-1:0]         free_entry_i,
    output logic [ENT_NUM*ENTLEN-1:0] entry_vector_o,
    output logic [ENT_NUM*VALLEN-1:0] value_vector_o,
    output logic [ENT_NUM-1:0]        valid_vector_o,
    output logic [ENTLEN:0]           count_o,
    output logic                      compact_busy_o
);

    localparam logic [VALLEN-1:0] AGE_INV = VALLEN'(age_invalid(VALLEN));
    localparam logic [VALLEN-1:0] AGE_LIM = VALLEN'(age_limit(VALLEN));

    state_e                    state_q, state_d;
    logic [ENT_NUM-1:0]        valid_q, valid_d;
    logic [ENT_NUM*VALLEN-1:0] age_q, age_d;
    logic [VALLEN-1:0]         counter_q, counter_d;

    logic [VALLEN-1:0]         counter_inc;
    logic                      free_found;
    logic [ENTLEN-1:0]         free_idx;
    logic                      free_hit;
    logic                      alloc_fire;
    logic [ENT_NUM*ENTLEN-1:0] rank;
    logic [ENTLEN:0]           live_count;

    age_rank_compactor #(
        .ENTLEN (ENTLEN),
        .VALLEN (VALLEN)
    ) u_compactor (
        .valid_i      (valid_q),
        .age_i        (age_q),
        .rank_o       (rank),
        .live_count_o (live_count)
    );

    // Lowest-index free slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = ENTLEN'(i);
            end
        end
    end

    assign free_hit    = free_valid_i && valid_q[free_entry_i];
    assign counter_inc = counter_q + 1'b1;

    // Grant: free_found is equivalent to count < 8.
    always_comb begin
        alloc_ready_o = 1'b0;
        alloc_entry_o = free_idx;
        if (state_q == ST_RUN) begin
            if (free_found) begin
                alloc_ready_o = 1'b1;
            end
`ifdef AGE_ALLOC_BYPASS_EN
            else if (free_hit) begin
                alloc_ready_o = 1'b1;
                alloc_entry_o = free_entry_i;
            end
`endif
        end
    end

    assign alloc_age_o = counter_q;
    assign alloc_fire  = alloc_req_i && alloc_ready_o;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        age_d     = age_q;
        counter_d = counter_q;

        // Free is applied before alloc so a bypassed slot ends up valid.
        if (free_hit) begin
            valid_d[free_entry_i] = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (alloc_fire) begin
                    for (int unsigned i = 0; i < ENT_NUM; i++) begin
                        if (ENTLEN'(i) == alloc_entry_o) begin
                            valid_d[i]                = 1'b1;
                            age_d[i*VALLEN +: VALLEN] = counter_q;
                        end
                    end
                    counter_d = counter_inc;
                    if (counter_inc == AGE_LIM) begin
                        state_d = ST_COMPACT;
                    end
                end
            end
            ST_COMPACT: begin
                // Ranks come from the pre-free valid set.
                for (int unsigned i = 0; i < ENT_NUM; i++) begin
                    if (valid_q[i]) begin
                        age_d[i*VALLEN +: VALLEN] = VALLEN'(rank[i*ENTLEN +: ENTLEN]);
                    end
                end
                counter_d = VALLEN'(live_count);
                state_d   = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            valid_q   <= '0;
            age_q     <= '0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            age_q     <= age_d;
            counter_q <= counter_d;
        end
    end

    always_comb begin
        entry_vector_o = '0;
        value_vector_o = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            entry_vector_o[i*ENTLEN +: ENTLEN] = ENTLEN'(i);
            value_vector_o[i*VALLEN +: VALLEN] = valid_q[i] ? age_q[i*VALLEN +: VALLEN] : AGE_INV;
        end
    end

    assign valid_vector_o = valid_q;
    assign count_o        = live_count;
    assign compact_busy_o = (state_q == ST_COMPACT);

endmodule

// File: doc/age_tag_allocator.md
# age_tag_allocator

Age-tag allocator for an 8-entry scheduling window. It hands out free entry slots together with strictly increasing age values, and frees slots when instructions leave. Each cycle it presents every slot's (index, age) pair in the packed layout consumed by the window's oldest-entry selector. When the age counter nears its ceiling, the block compacts all live ages so the "lower value is older" ordering never wraps.

## Interface
Parameters:
- ENTLEN, 3: entry index width; entry count is fixed at 8.
- VALLEN, 8: age value width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- alloc_req_i  in  1  allocation request
- alloc_ready_o  out  1  allocation can be accepted this cycle
- alloc_entry_o  out  ENTLEN  slot granted (lowest-index free slot)
- alloc_age_o  out  VALLEN  age granted (current counter)
- free_valid_i  in  1  release request
- free_entry_i  in  ENTLEN  slot to release
- entry_vector_o  out  8*ENTLEN  slot i carries constant index i at bits [i*ENTLEN +: ENTLEN]
- value_vector_o  out  8*VALLEN  slot i age at bits [i*VALLEN +: VALLEN]; all-ones if slot invalid
- valid_vector_o  out  8  per-slot valid
- count_o  out  ENTLEN+1  number of valid slots
- compact_busy_o  out  1  high in COMPACT state

## Operation
- Constants:
  - AGE_INVALID = 2^VALLEN-1.
  - AGE_LIMIT = 2^VALLEN-2.
  - Live ages are always < AGE_LIMIT, so an invalid slot never wins the oldest-entry comparison.
- States: RUN, COMPACT.
- RUN:
  - alloc_ready_o = (count_o < 8).
  - An allocation fires on alloc_req_i && alloc_ready_o.
  - alloc_entry_o = lowest-index invalid slot; alloc_age_o = counter. Both are combinational and meaningful only while alloc_ready_o = 1.
  - On fire: the slot becomes valid with that age next cycle, and counter increments.
  - If the incremented counter equals AGE_LIMIT, next state is COMPACT.
- COMPACT (exactly one cycle):
  - alloc_ready_o = 0.
  - Every valid slot's age is rewritten to its rank among valid slots: the count of valid slots with a smaller age, 0..7.
  - counter is set to the number of slots valid at the start of the cycle.
  - Next state is RUN. Compaction always makes progress because counter ≤ 8 < AGE_LIMIT.
- Free:
  - On free_valid_i, a valid free_entry_i slot is cleared next cycle.
  - Freeing an invalid slot is ignored; no state changes.
  - Frees are accepted in both states. During COMPACT, ranks are computed from the pre-free valid set, and the freed slot ends invalid.
- Simultaneous alloc and free in the same cycle:
  - The two slots are necessarily distinct, and both take effect.
  - count_o is unchanged.
  - With a full window and no bypass (see Configuration), alloc_ready_o = 0 even if a free is present.
- Reset (any time, including mid-COMPACT):
  - All slots invalid, counter = 0, state RUN.
  - alloc_ready_o = 1, alloc_entry_o = 0, alloc_age_o = 0.
  - value_vector_o all-ones, valid_vector_o = 0, count_o = 0, compact_busy_o = 0.
  - entry_vector_o is constant {7,6,...,0}.

## Timing
- Allocation and free take effect one cycle after the firing edge.
- value_vector_o, valid_vector_o and count_o are registered-state derived, with no input-to-output combinational path. The exception is the bypass below.
- Back-to-back allocations every cycle are sustained in RUN.
- Crossing AGE_LIMIT costs exactly one stall cycle.

## Configuration
- AGE_ALLOC_BYPASS_EN defined:
  - When count_o = 8 and free_valid_i targets a valid slot, alloc_ready_o = 1 and alloc_entry_o = free_entry_i.
  - A same-cycle free+alloc reuses that slot with the new age, and the slot stays valid.
  - This adds a combinational path from free_valid_i/free_entry_i to alloc_ready_o/alloc_entry_o.
  - Bypass is not available in COMPACT.
- Undefined: no bypass, and no combinational path from the free inputs.

## Structure
- Shared package holds:
  - entry count 8, ENTLEN/VALLEN defaults, AGE_INVALID and AGE_LIMIT functions;
  - the state enum {RUN, COMPACT}.
- Sub-module age_rank_compactor: combinational 8×8 age comparators gated by valid, with a per-slot 3-bit popcount producing the new ranks and the live count.
- Lowest-free priority encoder stays inline.

## Test plan
- Reset, then 3 allocations on consecutive cycles -> entries 0,1,2 with ages 0,1,2; count_o = 3; value_vector_o slots 3..7 = 0xFF.
- Free entry 1, then allocate -> entry 1 with age 3; free of already-invalid entry 5 -> no change in valid_vector_o or count_o.
- Fill all 8 slots -> alloc_ready_o = 0; free entry 4 with alloc_req_i held -> allocation fires the following cycle into slot 4.
- Keep entry 0 at age 0; repeatedly alloc/free entry 1 until counter reaches 254:
  - compact_busy_o = 1 for one cycle with alloc_ready_o = 0;
  - then entry 0 age = 0, entry 1 age = 1, next alloc_age_o = 2.
- Assert rst_i during COMPACT -> outputs immediately return to reset values; first allocation after release gives entry 0, age 0.
- With AGE_ALLOC_BYPASS_EN, full window plus free entry 6 and alloc_req_i in the same cycle -> alloc_entry_o = 6; count_o stays 8; slot 6 age = the prior counter.
